mig_seq_eval: RTL and testbench
===============================

// Module: mig_seq_eval
// PURPOSE
//  Time-multiplexed majority-graph evaluator: one shared MAJ3 unit executes a stored node program,
//  one node per cycle, over a primary-input vector. Sits beside combinational MIG benchmark nets as
//  their sequenced, area-minimal equivalent; the last evaluated node drives po.
// PARAMETERS
//  NUM_PI     18   primary inputs captured per run
//  MAX_NODES  16   program table depth (majority nodes)
//  IDX_W      6    operand index width; must satisfy 2**IDX_W >= NUM_PI+MAX_NODES
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  pi_vec     in   NUM_PI             primary inputs, sampled on accepted start
//  start      in   1                  begin run; accepted only in IDLE
//  num_nodes  in   $clog2(MAX_NODES+1) node count, sampled with start
//  prog_we    in   1                  program write strobe; honoured only in IDLE
//  prog_addr  in   $clog2(MAX_NODES)  node slot written
//  prog_a/b/c in   IDX_W each         operand indices: 0..NUM_PI-1 = pi, NUM_PI+k = node k
//  prog_inv   in   3                  per-operand complement {c,b,a} (MIG_INV_EN only)
//  busy       out  1                  high LOAD..EVAL
//  done       out  1                  one-cycle pulse, result valid
//  po         out  1                  value of node num_nodes-1; held until next done
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, po=0; value file cleared. Program table NOT reset.
//  - FSM: IDLE -start-> LOAD (pi_vec to value[0..NUM_PI-1], node slots cleared to 0, node ptr=0)
//    -> EVAL (cycle k: value[NUM_PI+k] <= MAJ(op_a,op_b,op_c) for node k; ptr++)
//    -> after node num_nodes-1: DONE (po <= last node value, done=1) -> IDLE.
//  - Latency: start accepted at cycle 0 -> done at cycle num_nodes+2.
//  - num_nodes==0: LOAD -> DONE directly, po=0, done at cycle 2.
//  - num_nodes>MAX_NODES: clamped to MAX_NODES.
//  - Operand index >= NUM_PI+k (forward/self reference) or out of range reads 0; no error flag.
//  - start while busy: ignored. prog_we while busy: ignored (program stable during a run).
//  - start and prog_we same cycle in IDLE: write commits, run uses the new entry.
//  - rst mid-run: abort to IDLE, no done pulse, po=0.
//  - MAJ(a,b,c) = ab|ac|bc; result registered into value file, read same cycle by later nodes'
//    operand mux next cycle (no bypass needed: one node per cycle).
// CONFIGURATION
//  MIG_INV_EN defined: program entry stores prog_inv; each operand XORed with its inv bit before
//   MAJ3 (complemented edges, full MIG).
//  MIG_INV_EN undefined: prog_inv ignored and not stored; pure monotone majority network.
// STRUCTURE
//  Package mig_seq_pkg: state_t enum {IDLE,LOAD,EVAL,DONE}; node_t struct {a,b,c idx[,inv]};
//   helper function maj3(). Sub-module mig_maj3_unit: three operand muxes + optional inverters +
//   MAJ3, purely combinational; FSM, program table and value file stay in mig_seq_eval.
// TESTING
//  1 reset: assert rst 2 cycles -> busy=0, done=0, po=0; then start with num_nodes=0 -> done at
//    cycle 2, po=0.
//  2 single node MAJ(pi0,pi1,pi2): pi[2:0]=3'b011 -> po=1 at cycle 3; 3'b001 -> po=0.
//  3 chained 10-node program (6 input majorities, 4 cascaded on nodes), all pi=1 -> po=1 at
//    cycle 12; all pi=0 -> po=0; random vectors vs. golden combinational model, 1000 runs.
//  4 start and prog_we during EVAL -> both ignored; result equals pre-run program; next run
//    after done uses unchanged table.
//  5 rst asserted at EVAL cycle 3 of a 10-node run -> no done, po=0, IDLE next cycle; new start
//    completes normally.
//  6 MIG_INV_EN: node MAJ(~pi0,pi1,pi2), pi=3'b000 -> po=0; inv=3'b011 same pi -> po=1;
//    build without macro: inv bits ignored -> po=0 both cases.

Source files
------------

// File: rtl/mig_seq_pkg.sv
// Shared sizes, types and the majority helper for the sequenced majority-graph evaluator.
// MIG_INV_EN adds per-operand complement bits to every stored program entry.
package mig_seq_pkg;

    localparam int NUM_PI    = 18;
    localparam int MAX_NODES = 16;
    localparam int IDX_W     = 6;
    localparam int VAL_W     = NUM_PI + MAX_NODES;
    localparam int CNT_W     = $clog2(MAX_NODES + 1);
    localparam int PTR_W     = $clog2(MAX_NODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
`ifdef MIG_INV_EN
        logic [2:0]       inv;
`endif
        logic [IDX_W-1:0] c;
        logic [IDX_W-1:0] b;
        logic [IDX_W-1:0] a;
    } node_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mig_maj3_unit.sv
// Shared MAJ3 datapath: three operand selects from the value file, optional complements, majority.
// Complemented operands exist only when MIG_INV_EN is defined.
module mig_maj3_unit
    import mig_seq_pkg::*;
(
    input  logic [VAL_W-1:0] value_vec,
    input  node_t            node,
    input  logic [PTR_W-1:0] node_idx,
    output logic             result
);

    localparam logic [IDX_W:0] PI_BASE = NUM_PI[IDX_W:0];

    logic [IDX_W:0] limit;
    logic           op_a;
    logic           op_b;
    logic           op_c;

    // Only primary inputs and already-evaluated nodes are legal sources; anything else reads 0.
    function automatic logic read_op(input logic [IDX_W-1:0] idx,
                                     input logic [IDX_W:0]   lim,
                                     input logic [VAL_W-1:0] vals);
        return ({1'b0, idx} < lim) ? vals[idx] : 1'b0;
    endfunction

    always_comb begin
        limit = PI_BASE + {{(IDX_W + 1 - PTR_W){1'b0}}, node_idx};
        op_a  = read_op(node.a, limit, value_vec);
        op_b  = read_op(node.b, limit, value_vec);
        op_c  = read_op(node.c, limit, value_vec);
`ifdef MIG_INV_EN
        op_a  = op_a ^ node.inv[0];
        op_b  = op_b ^ node.inv[1];
        op_c  = op_c ^ node.inv[2];
`endif
        result = maj3(op_a, op_b, op_c);
    end

endmodule

// File: rtl/mig_seq_eval.sv
// Time-multiplexed majority-graph evaluator: one node of the stored program per cycle, last node drives po.
// Build with MIG_INV_EN defined for complemented edges; default is a monotone majority network.
module mig_seq_eval
    import mig_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PI-1:0] pi_vec,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_nodes,
    input  logic              prog_we,
    input  logic [PTR_W-1:0]  prog_addr,
    input  logic [IDX_W-1:0]  prog_a,
    input  logic [IDX_W-1:0]  prog_b,
    input  logic [IDX_W-1:0]  prog_c,
    input  logic [2:0]        prog_inv,
    output logic              busy,
    output logic              done,
    output logic              po,
    output state_t            dbg_state
);

    // Handshake: start and prog_we are sampled only while IDLE; done pulses one cycle and po holds until the next done.

    localparam logic [IDX_W-1:0] PI_BASE = NUM_PI[IDX_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = MAX_NODES[CNT_W-1:0];

    node_t            prog_q [MAX_NODES];
    node_t            prog_d [MAX_NODES];
    node_t            wr_node;
    node_t            cur_node;
    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             done_q, done_d;
    logic             po_q, po_d;
    logic             maj_out;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] last_idx;

    always_comb begin
        wr_node   = '0;
        wr_node.a = prog_a;
        wr_node.b = prog_b;
        wr_node.c = prog_c;
`ifdef MIG_INV_EN
        wr_node.inv = prog_inv;
`endif
    end

`ifndef MIG_INV_EN
    logic unused_inv;
    assign unused_inv = ^prog_inv;
`endif

    assign cur_node = prog_q[ptr_q];
    assign wr_idx   = PI_BASE + {{(IDX_W - PTR_W){1'b0}}, ptr_q};
    assign last_idx = PI_BASE + {{(IDX_W - CNT_W){1'b0}}, cnt_q} - IDX_W'(1);

    mig_maj3_unit u_maj3 (
        .value_vec (value_q),
        .node      (cur_node),
        .node_idx  (ptr_q),
        .result    (maj_out)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        done_d  = 1'b0;
        po_d    = po_q;
        prog_d  = prog_q;
        case (state_q)
            IDLE: begin
                if (prog_we) begin
                    prog_d[prog_addr] = wr_node;
                end
                // pi_vec is captured on the accepting edge so LOAD needs no copy of it.
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = (num_nodes > CNT_MAX) ? CNT_MAX : num_nodes;
                    value_d = {{MAX_NODES{1'b0}}, pi_vec};
                end
            end
            LOAD: begin
                ptr_d   = '0;
                state_d = (cnt_q == '0) ? DONE : EVAL;
            end
            EVAL: begin
                value_d[wr_idx] = maj_out;
                if ({1'b0, ptr_q} == cnt_q - CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                po_d    = (cnt_q == '0) ? 1'b0 : value_q[last_idx];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
            po_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            done_q  <= done_d;
            po_q    <= po_d;
        end
    end

    // The program table survives reset so a loaded program can be rerun after an abort.
    always_ff @(posedge clk) begin
        prog_q <= prog_d;
    end

    assign busy      = (state_q == LOAD) || (state_q == EVAL);
    assign done      = done_q;
    assign po        = po_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Self-checking bench for mig_seq_eval: directed and random runs against a node-list reference model.
module tb_mig_seq_eval;
    import mig_seq_pkg::*;

    logic              clk;
    logic              rst;
    logic [NUM_PI-1:0] pi_vec;
    logic              start;
    logic [CNT_W-1:0]  num_nodes;
    logic              prog_we;
    logic [PTR_W-1:0]  prog_addr;
    logic [IDX_W-1:0]  prog_a;
    logic [IDX_W-1:0]  prog_b;
    logic [IDX_W-1:0]  prog_c;
    logic [2:0]        prog_inv;
    logic              busy;
    logic              done;
    logic              po;
    state_t            dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [0:0] exp_q[$];

    int tb_a [MAX_NODES];
    int tb_b [MAX_NODES];
    int tb_c [MAX_NODES];
`ifdef MIG_INV_EN
    logic [2:0] tb_inv [MAX_NODES];
`endif

    mig_seq_eval dut (
        .clk       (clk),
        .rst       (rst),
        .pi_vec    (pi_vec),
        .start     (start),
        .num_nodes (num_nodes),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_a    (prog_a),
        .prog_b    (prog_b),
        .prog_c    (prog_c),
        .prog_inv  (prog_inv),
        .busy      (busy),
        .done      (done),
        .po        (po),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Evaluate the node list directly: node k may read pi or nodes 0..k-1, anything else is 0.
    function automatic logic model_po(input logic [NUM_PI-1:0] pi, input int nc);
        int vals [64];
        int ops  [3];
        int idx  [3];
        for (int i = 0; i < 64; i++) vals[i] = 0;
        for (int i = 0; i < NUM_PI; i++) vals[i] = pi[i] ? 1 : 0;
        for (int k = 0; k < nc; k++) begin
            idx[0] = tb_a[k];
            idx[1] = tb_b[k];
            idx[2] = tb_c[k];
            for (int j = 0; j < 3; j++) begin
                ops[j] = (idx[j] < NUM_PI + k) ? vals[idx[j]] : 0;
`ifdef MIG_INV_EN
                if (tb_inv[k][j]) ops[j] = 1 - ops[j];
`endif
            end
            vals[NUM_PI + k] = (ops[0] + ops[1] + ops[2] >= 2) ? 1 : 0;
        end
        return (nc == 0) ? 1'b0 : (vals[NUM_PI + nc - 1] != 0);
    endfunction

    task automatic stage_node(input int addr, input int a, input int b, input int c, input logic [2:0] inv);
        prog_addr = PTR_W'(addr);
        prog_a    = IDX_W'(a);
        prog_b    = IDX_W'(b);
        prog_c    = IDX_W'(c);
        prog_inv  = inv;
        tb_a[addr] = a;
        tb_b[addr] = b;
        tb_c[addr] = c;
`ifdef MIG_INV_EN
        tb_inv[addr] = inv;
`endif
    endtask

    task automatic write_node(input int addr, input int a, input int b, input int c, input logic [2:0] inv);
        @(negedge clk);
        stage_node(addr, a, b, c, inv);
        prog_we = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // kind: 0 plain, 1 start+prog_we injected mid-run, 2 reset mid-run, 3 prog_we with start.
    task automatic run(input logic [NUM_PI-1:0] pi, input int n, input int kind, input int evt_at);
        int nc;
        int lat;
        logic reached;
        logic [0:0] exp_po;
        nc      = (n > MAX_NODES) ? MAX_NODES : n;
        lat     = -1;
        reached = 1'b0;
        if (kind != 2) exp_q.push_back(model_po(pi, nc));
        @(negedge clk);
        pi_vec    = pi;
        num_nodes = CNT_W'(n);
        start     = 1'b1;
        if (kind == 3) prog_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            start   = 1'b0;
            prog_we = 1'b0;
            rst     = 1'b0;
            if (i == 0) check("busy_after_start", busy, 1);
            if (kind == 2 && i == evt_at + 1) begin
                reached = 1'b1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_po", po, 0);
                check("rst_state", dbg_state, IDLE);
                break;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (i == evt_at && kind == 1) begin
                start     = 1'b1;
                num_nodes = CNT_W'(1);
                pi_vec    = ~pi;
                prog_we   = 1'b1;
                prog_addr = PTR_W'(nc - 1);
                prog_a    = '1;
                prog_b    = '1;
                prog_c    = '1;
                prog_inv  = 3'b000;
            end
            if (i == evt_at && kind == 2) rst = 1'b1;
        end
        if (kind == 2) begin
            check("rst_abort_reached", reached, 1);
        end else begin
            exp_po = exp_q.pop_front();
            check("latency", lat, nc + 2);
            check("po", po, exp_po);
            @(negedge clk);
            check("done_pulse", done, 0);
            check("po_hold", po, exp_po);
        end
    endtask

    task automatic load_chain10();
        write_node(0, 0, 1, 2, 3'b000);
        write_node(1, 3, 4, 5, 3'b000);
        write_node(2, 6, 7, 8, 3'b000);
        write_node(3, 9, 10, 11, 3'b000);
        write_node(4, 12, 13, 14, 3'b000);
        write_node(5, 15, 16, 17, 3'b000);
        write_node(6, NUM_PI + 0, NUM_PI + 1, NUM_PI + 2, 3'b000);
        write_node(7, NUM_PI + 3, NUM_PI + 4, NUM_PI + 5, 3'b000);
        write_node(8, NUM_PI + 6, NUM_PI + 7, 0, 3'b000);
        write_node(9, NUM_PI + 6, NUM_PI + 7, NUM_PI + 8, 3'b000);
    endtask

    initial begin
        logic [NUM_PI-1:0] ones;
        ones      = '1;
        rst       = 1'b1;
        pi_vec    = '0;
        start     = 1'b0;
        num_nodes = '0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_a    = '0;
        prog_b    = '0;
        prog_c    = '0;
        prog_inv  = '0;

        // Reset state and the empty program.
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_po", po, 0);
        check("reset_state", dbg_state, IDLE);
        rst = 1'b0;
        for (int s = 0; s < MAX_NODES; s++) write_node(s, 0, 0, 0, 3'b000);
        run('0, 0, 0, -1);

        // Single node MAJ(pi0,pi1,pi2).
        write_node(0, 0, 1, 2, 3'b000);
        run(NUM_PI'(3'b011), 1, 0, -1);
        run(NUM_PI'(3'b001), 1, 0, -1);

        // Write and start in the same cycle: the run sees the new entry.
        stage_node(0, 3, 4, 5, 3'b000);
        run(NUM_PI'(6'b000_011), 1, 3, -1);

        // Ten-node chained program.
        load_chain10();
        run(ones, 10, 0, -1);
        run('0, 10, 0, -1);
        for (int r = 0; r < 1000; r++) run(NUM_PI'($urandom), 10, 0, -1);

        // Start and program write during EVAL are ignored; the table is unchanged afterwards.
        run(ones, 10, 1, 3);
        run(ones, 10, 0, -1);

        // Reset in the middle of EVAL, then a normal run.
        run(ones, 10, 2, 4);
        run(ones, 10, 0, -1);

        // Complemented operands (ignored in the default build).
        write_node(0, 0, 1, 2, 3'b001);
        run('0, 1, 0, -1);
        write_node(0, 0, 1, 2, 3'b011);
        run('0, 1, 0, -1);

        // Random programs, including forward/out-of-range operands and clamped counts.
        for (int p = 0; p < 20; p++) begin
            for (int s = 0; s < MAX_NODES; s++)
                write_node(s, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                           3'($urandom_range(0, 7)));
            for (int r = 0; r < 10; r++) run(NUM_PI'($urandom), $urandom_range(0, 20), 0, -1);
        end
        run(NUM_PI'($urandom), 31, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
